rom_dl_bridge: RTL
==================

ROM_DL_BRIDGE -- requirements
Module: rom_dl_bridge

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of 16-bit write entries buffered (power of two, 2..16).
REQ-002 SHALL have ports, clock and reset first:
clk_sys  in  1  system clock; all logic on rising edge
reset_n  in  1  asynchronous active-low reset
ioctl_download  in  1  high while a ROM download is active
ioctl_wr  in  1  byte strobe, may be multi-cycle; the rising edge counts
ioctl_addr  in  25  byte address of ioctl_dout
ioctl_dout  in  8  download byte
port1_req  out  1  SDRAM request toggle
port1_ack  in  1  SDRAM acknowledge toggle; request complete when equal to port1_req
port1_a  out  23  SDRAM word address
port1_ds  out  2  byte enables, bit1 = upper byte
port1_we  out  1  write enable
port1_d  out  16  write data
busy  out  1  pending word, FIFO entry or outstanding request exists
overflow  out  1  sticky: a byte was dropped
rom_loaded  out  1  download finished and fully written
REQ-003 SHALL be a single clock domain (clk_sys) with asynchronous, active-low reset_n; no other clocks.

Function
REQ-004 SHALL detect byte accepts on the ioctl_wr rising edge (registered previous value) only while ioctl_download=1.
REQ-005 SHALL keep one pending-word register {word address = ioctl_addr[23:1], ds, data}; byte lane = ioctl_addr[0]; an even byte goes in data[7:0] with ds[0], an odd byte in data[15:8] with ds[1].
REQ-006 SHALL merge an accepted byte into the pending word when pending is valid, the word address matches, and that lane's ds bit is clear.
REQ-007 Otherwise SHALL push the pending word, if valid, into the FIFO in the same cycle and load the new byte as pending.
REQ-008 SHALL push the pending word as soon as ds=11, without waiting for the next byte.
REQ-009 SHALL flush the pending word into the FIFO on the falling edge of ioctl_download.
REQ-010 FIFO full with a push required: SHALL drop the push and set overflow; the pending register still loads the new byte.
REQ-010a overflow SHALL clear only on reset or on the rising edge of ioctl_download.
REQ-011 Issue FSM states: SYNC, IDLE, WAIT_ACK.
REQ-011a SYNC: entered after reset; sets port1_req <= port1_ack, then goes to IDLE.
REQ-011b IDLE: when the FIFO is non-empty, drives port1_a/ds/d from the FIFO head, toggles port1_req, pops the FIFO, and goes to WAIT_ACK.
REQ-011c WAIT_ACK: returns to IDLE when port1_ack==port1_req.
REQ-012 Outputs port1_a/ds/d SHALL stay stable from the req toggle until the ack match.
REQ-012a At most one request SHALL be outstanding.
REQ-013 port1_we SHALL be 1 while ioctl_download=1 or busy=1, and 0 otherwise.
REQ-014 When a push and a pop happen in the same cycle, the FIFO count SHALL stay unchanged; a push while full-with-pop SHALL succeed.
REQ-015 Latency: an isolated full word SHALL be pushed 1 cycle after its second byte's edge, and port1_req SHALL toggle 1 cycle after the push (FSM in IDLE).
REQ-016 rom_loaded SHALL go to 1 on the first cycle where ioctl_download=0, a download has ended since reset, and busy=0; it SHALL clear on the rising edge of ioctl_download.
REQ-017 A new download starting while the previous one is still draining SHALL not discard queued entries.
REQ-018 FIFO pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-019 While reset_n=0 SHALL drive: port1_req=0, port1_a=0, port1_ds=0, port1_d=0, port1_we=0, busy=0, overflow=0, rom_loaded=0; the FIFO and pending register are empty and the FSM is in SYNC.
REQ-020 Reset mid-download SHALL abandon all buffered bytes and any outstanding request; after release the block SHALL resynchronise via SYNC with no spurious request.

Verification
REQ-021 Bytes 0x11@0, 0x22@1, ack after 3 cycles -> one request: a=0, ds=11, d=0x2211, we=1.
REQ-022 Single byte 0xAB@5 then download falls -> flush request: a=2, ds=10, d=0xAB00; rom_loaded=1 after ack.
REQ-023 Ack held off while 6 full words arrive, FIFO_DEPTH=4 -> overflow=1; exactly the first 5 words written in order (1 in flight + 4 queued); the 6th is dropped.
REQ-024 Reset pulse with port1_ack=1 held -> after release port1_req=1 by SYNC, then no toggle while the FIFO is empty.
REQ-025 Bytes @3 then @2 (odd before even) -> one request: a=1, ds=11, d={b@3,b@2}.
REQ-026 Reset asserted while in WAIT_ACK -> all outputs go to their REQ-019 values immediately; a later download completes normally.

Source files
------------

// File: rtl/rom_dl_bridge.sv
// Packs a byte-wide ROM download stream into 16-bit SDRAM writes.
// A pending word collects byte lanes, a small FIFO buffers whole words, and a toggle handshake issues them.
module rom_dl_bridge #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        port1_req,
    input  logic        port1_ack,
    output logic [22:0] port1_a,
    output logic [1:0]  port1_ds,
    output logic        port1_we,
    output logic [15:0] port1_d,
    output logic        busy,
    output logic        overflow,
    output logic        rom_loaded
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] DepthC = CntW'(FIFO_DEPTH);

    typedef struct packed {
        logic [22:0] addr;
        logic [1:0]  ds;
        logic [15:0] data;
    } entry_t;

    typedef enum logic [1:0] {StSync, StIdle, StWaitAck} state_e;

    logic            wr_q, dl_q;
    logic            pend_valid_q, pend_valid_d;
    entry_t          pend_q, pend_d;
    entry_t          mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0] count_q, count_d;
    state_e          state_q, state_d;
    logic            req_q, req_d;
    entry_t          out_q, out_d;
    logic            overflow_q, overflow_d;
    logic            ended_q, ended_d;
    logic            loaded_q, loaded_d;

    logic accept, dl_rise, dl_fall, lane, merge, push, pop, push_ok, busy_w;
    logic unused_addr;

    assign unused_addr = ioctl_addr[24];
    assign lane        = ioctl_addr[0];
    assign accept      = ioctl_download && ioctl_wr && !wr_q;
    assign dl_rise     = ioctl_download && !dl_q;
    assign dl_fall     = !ioctl_download && dl_q;

    always_comb begin
        merge = accept && pend_valid_q && (ioctl_addr[23:1] == pend_q.addr) && !pend_q.ds[lane];
        // A complete word leaves immediately; a partial one leaves on address change or download end.
        push = pend_valid_q && ((accept && !merge) || (pend_q.ds == 2'b11) || dl_fall);
        pop = (state_q == StIdle) && (count_q != '0);
        push_ok = push && ((count_q != DepthC) || pop);
        busy_w = pend_valid_q || (count_q != '0) || (state_q == StWaitAck);
    end

    always_comb begin
        pend_valid_d = pend_valid_q;
        pend_d       = pend_q;
        if (accept && merge) begin
            pend_d.ds[lane] = 1'b1;
            if (lane) pend_d.data[15:8] = ioctl_dout;
            else      pend_d.data[7:0]  = ioctl_dout;
        end else if (accept) begin
            pend_valid_d = 1'b1;
            pend_d.addr  = ioctl_addr[23:1];
            pend_d.ds    = lane ? 2'b10 : 2'b01;
            pend_d.data  = lane ? {ioctl_dout, 8'h00} : {8'h00, ioctl_dout};
        end else if (push) begin
            pend_valid_d = 1'b0;
        end
    end

    always_comb begin
        wptr_d  = push_ok ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = pop ? rptr_q + 1'b1 : rptr_q;
        count_d = count_q + CntW'(push_ok) - CntW'(pop);
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        out_d   = out_q;
        case (state_q)
            StSync: begin
                req_d   = port1_ack;
                state_d = StIdle;
            end
            StIdle: begin
                if (pop) begin
                    out_d   = mem_q[rptr_q];
                    req_d   = ~req_q;
                    state_d = StWaitAck;
                end
            end
            StWaitAck: begin
                if (port1_ack == req_q) state_d = StIdle;
            end
            default: state_d = StSync;
        endcase
    end

    always_comb begin
        overflow_d = overflow_q;
        if (dl_rise) overflow_d = 1'b0;
        if (push && !push_ok) overflow_d = 1'b1;
        ended_d  = ended_q || dl_fall;
        loaded_d = loaded_q;
        if (dl_rise) loaded_d = 1'b0;
        else if (!ioctl_download && ended_q && !busy_w) loaded_d = 1'b1;
    end

    always_ff @(posedge clk_sys) begin
        if (push_ok) mem_q[wptr_q] <= pend_q;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_q         <= 1'b0;
            dl_q         <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_q       <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            state_q      <= StSync;
            req_q        <= 1'b0;
            out_q        <= '0;
            overflow_q   <= 1'b0;
            ended_q      <= 1'b0;
            loaded_q     <= 1'b0;
        end else begin
            wr_q         <= ioctl_wr;
            dl_q         <= ioctl_download;
            pend_valid_q <= pend_valid_d;
            pend_q       <= pend_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            state_q      <= state_d;
            req_q        <= req_d;
            out_q        <= out_d;
            overflow_q   <= overflow_d;
            ended_q      <= ended_d;
            loaded_q     <= loaded_d;
        end
    end

    assign port1_req  = req_q;
    assign port1_a    = out_q.addr;
    assign port1_ds   = out_q.ds;
    assign port1_d    = out_q.data;
    assign busy       = busy_w;
    // Registered download flag keeps we low while reset is held.
    assign port1_we   = dl_q || busy_w;
    assign overflow   = overflow_q;
    assign rom_loaded = loaded_q;

endmodule
